// File: rtl/motion_pkg.sv
// Shared types and constants for the stepper motion sequencer.
package motion_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  typedef enum logic {
    MODE_MOVE = 1'b0,
    MODE_HOME = 1'b1
  } mode_t;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_LIMIT   = 2'b01;
  localparam logic [1:0] STATUS_ABORT   = 2'b10;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

  // Entry n drives coil n; the index wraps 3 <-> 0.
  localparam logic [3:0][3:0] PHASE_TABLE = {4'b1000, 4'b0100, 4'b0010, 4'b0001};

  function automatic logic [3:0] phase_coil(input logic [1:0] idx);
    return PHASE_TABLE[idx];
  endfunction

endpackage

// File: rtl/stepper_axis.sv
// One stepper axis: period timer, remaining-step counter, phase index,
// limit check and per-command result flags.
module stepper_axis
  import motion_pkg::*;
#(
  parameter int STEPW   = 12,
  parameter int PERIODW = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               kill,
  input  logic               home,
  input  logic               dir_in,
  input  logic [STEPW-1:0]   steps_in,
  input  logic [PERIODW-1:0] step_period,
  input  logic               limit_lo,
  input  logic               limit_hi,
  output logic [3:0]         coil,
  output logic               active,
  output logic               limit_flag,
  output logic               timeout_flag
);

  localparam logic [STEPW-1:0]   ONE_STEP  = STEPW'(1);
  localparam logic [PERIODW-1:0] ONE_CYCLE = PERIODW'(1);

  logic               dir_r;
  logic               home_r;
  logic [STEPW-1:0]   remaining_r;
  logic [PERIODW-1:0] timer_r;
  logic [1:0]         phase_r;

  logic [PERIODW-1:0] period_last_s;
  logic               expire_s;
  logic               at_limit_s;
  logic [1:0]         phase_next_s;

  // Step-instant decode; a zero period behaves as a one-cycle period.
  always_comb begin
    period_last_s = (step_period == '0) ? '0 : (step_period - ONE_CYCLE);
    expire_s      = active && (timer_r == period_last_s);
    at_limit_s    = dir_r ? limit_hi : limit_lo;
    phase_next_s  = dir_r ? (phase_r + 2'd1) : (phase_r - 2'd1);
  end

  // Axis state: kill beats load, load beats stepping.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_r        <= 1'b0;
      home_r       <= 1'b0;
      remaining_r  <= '0;
      timer_r      <= '0;
      phase_r      <= 2'd0;
      coil         <= phase_coil(2'd0);
      active       <= 1'b0;
      limit_flag   <= 1'b0;
      timeout_flag <= 1'b0;
    end else if (kill) begin
      active      <= 1'b0;
      remaining_r <= '0;
      timer_r     <= '0;
    end else if (load) begin
      home_r       <= home;
      dir_r        <= home ? 1'b0 : dir_in;
      remaining_r  <= home ? '1 : steps_in;
      active       <= home ? 1'b1 : (steps_in != '0);
      timer_r      <= '0;
      limit_flag   <= 1'b0;
      timeout_flag <= 1'b0;
    end else if (expire_s) begin
      timer_r <= '0;
      if (at_limit_s) begin
        // Switch closed in the direction of travel: stop without stepping.
        remaining_r <= '0;
        active      <= 1'b0;
        limit_flag  <= !home_r;
      end else begin
        phase_r     <= phase_next_s;
        coil        <= phase_coil(phase_next_s);
        remaining_r <= remaining_r - ONE_STEP;
        if (remaining_r == ONE_STEP) begin
          active       <= 1'b0;
          timeout_flag <= home_r;
        end else begin
          active <= 1'b1;
        end
      end
    end else if (active) begin
      timer_r <= timer_r + ONE_CYCLE;
    end else begin
      timer_r <= timer_r;
    end
  end

endmodule

// File: rtl/motion_sequencer.sv
// Multi-axis stepper sequencer: command handshake, FSM, command latch and
// status encoding around NAXES independent stepper_axis instances.
module motion_sequencer
  import motion_pkg::*;
#(
  parameter int NAXES   = 2,
  parameter int STEPW   = 12,
  parameter int PERIODW = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_mode,
  input  logic [NAXES-1:0]         cmd_dir,
  input  logic [NAXES*STEPW-1:0]   cmd_steps,
  input  logic [PERIODW-1:0]       step_period,
  input  logic [NAXES-1:0]         limit_lo,
  input  logic [NAXES-1:0]         limit_hi,
  input  logic                     abort,
  output logic [4*NAXES-1:0]       coil,
  output logic [NAXES-1:0]         axis_active,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               status
);

  state_t                   state_r;
  mode_t                    mode_r;
  logic [NAXES-1:0]         dir_r;
  logic [NAXES*STEPW-1:0]   steps_r;
  logic                     start_r;

  logic [NAXES-1:0]         limit_flags_s;
  logic [NAXES-1:0]         timeout_flags_s;
  logic                     kill_s;
  logic                     home_s;

  // Abort only acts while running; HOME selection from the latched mode.
  always_comb begin
    kill_s = (state_r == ST_RUN) && abort;
    home_s = (mode_r == MODE_HOME);
  end

  for (genvar i = 0; i < NAXES; i++) begin : g_axis
    stepper_axis #(
      .STEPW   (STEPW),
      .PERIODW (PERIODW)
    ) u_axis (
      .clk          (clk),
      .reset        (reset),
      .load         (start_r),
      .kill         (kill_s),
      .home         (home_s),
      .dir_in       (dir_r[i]),
      .steps_in     (steps_r[i*STEPW +: STEPW]),
      .step_period  (step_period),
      .limit_lo     (limit_lo[i]),
      .limit_hi     (limit_hi[i]),
      .coil         (coil[4*i +: 4]),
      .active       (axis_active[i]),
      .limit_flag   (limit_flags_s[i]),
      .timeout_flag (timeout_flags_s[i])
    );
  end

  // Sequencer FSM with registered handshake, done pulse and status.
  // start_r marks the cycle the axes load, so RUN never sees stale inactivity.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      mode_r    <= MODE_MOVE;
      dir_r     <= '0;
      steps_r   <= '0;
      start_r   <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      status    <= STATUS_OK;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (cmd_valid) begin
            mode_r    <= mode_t'(cmd_mode);
            dir_r     <= cmd_dir;
            steps_r   <= cmd_steps;
            start_r   <= 1'b1;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state_r   <= ST_RUN;
          end else begin
            start_r <= 1'b0;
          end
        end
        ST_RUN: begin
          start_r <= 1'b0;
          if (abort) begin
            status  <= STATUS_ABORT;
            done    <= 1'b1;
            state_r <= ST_FINISH;
          end else if (!start_r && (axis_active == '0)) begin
            if (|timeout_flags_s) begin
              status <= STATUS_TIMEOUT;
            end else if (|limit_flags_s) begin
              status <= STATUS_LIMIT;
            end else begin
              status <= STATUS_OK;
            end
            done    <= 1'b1;
            state_r <= ST_FINISH;
          end else begin
            done <= 1'b0;
          end
        end
        ST_FINISH: begin
          done      <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          start_r   <= 1'b0;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/motion_sequencer.md
MOTION_SEQUENCER -- requirements
Module: motion_sequencer

Interface
REQ-001 Parameter NAXES, default 2: number of stepper axes.
REQ-002 Parameter STEPW, default 12: width of the per-axis step count.
REQ-003 Parameter PERIODW, default 20: width of the step-period count.
REQ-004 clk  in  1  clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  high only in IDLE.
REQ-008 cmd_mode  in  1  0 = MOVE, 1 = HOME.
REQ-009 cmd_dir  in  NAXES  per-axis direction; 1 = toward limit_hi.
REQ-010 cmd_steps  in  NAXES*STEPW  per-axis step count; axis i occupies bits [i*STEPW +: STEPW].
REQ-011 step_period  in  PERIODW  clk cycles per step; static during a command; 0 treated as 1.
REQ-012 limit_lo, limit_hi  in  NAXES each  boundary switches, active-high, already synchronised.
REQ-013 abort  in  1  stop all axes.
REQ-014 coil  out  4*NAXES  one-hot coil drive; axis i occupies bits [4i+3:4i].
REQ-015 axis_active  out  NAXES  axis has steps remaining.
REQ-016 busy  out  1  high when not in IDLE.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 status  out  2  result of the last command, valid from the done pulse until the next accept: 00 ok, 01 limit hit, 10 aborted, 11 home timeout.

Function
REQ-019 FSM states: IDLE, RUN, FINISH.
REQ-020 IDLE -> RUN on cmd_valid && cmd_ready; the command is latched in that cycle.
REQ-021 In any state other than IDLE, cmd_valid is ignored and no command is latched.
REQ-022 MOVE: axis i loads cmd_steps[i] and cmd_dir[i]; an axis loaded with 0 steps is inactive from the start.
REQ-023 HOME: every axis loads direction 0 and 2^STEPW-1 steps; cmd_dir and cmd_steps are ignored.
REQ-024 Per active axis, a period timer counts step_period cycles; on expiry the phase index moves one position and the remaining count decrements.
REQ-025 Phase index steps +1 (mod 4) for direction 1 and -1 (mod 4) for direction 0.
REQ-026 Phase table: index 0..3 -> coil 0001, 0010, 0100, 1000; the index wraps 3 <-> 0.
REQ-027 Latency: for a command accepted at edge T, the first coil change is at edge T+1+step_period.
REQ-028 Limit check at each step instant: if limit_hi (direction 1) or limit_lo (direction 0) is high, no step is taken, remaining is cleared and the axis goes inactive.
REQ-029 In MOVE, a limit stop as in REQ-028 sets the limit flag.
REQ-030 In HOME, stopping on limit_lo is the success condition and does not set the limit flag.
REQ-031 In HOME, an axis that exhausts its count without reaching limit_lo sets the timeout flag.
REQ-032 RUN -> FINISH on the first cycle in which every axis is inactive.
REQ-033 Zero-step MOVE: done pulses 2 cycles after accept and coil does not change.
REQ-034 FINISH: done = 1 for exactly one cycle, status is updated in the same cycle, and the next state is IDLE.
REQ-035 Status priority: abort > timeout > limit > ok.
REQ-036 abort in RUN: all axes go inactive on the next edge, no further steps are taken, and the next state is FINISH with status 10.
REQ-037 abort in IDLE or FINISH has no effect.
REQ-038 Between commands, coil holds the last phase (holding torque) and is never all-zero.
REQ-039 All NAXES axes step concurrently and independently; all period timers restart on accept.

Reset
REQ-040 Reset values: state IDLE, cmd_ready 1, busy 0, done 0, status 00, axis_active 0, all phase indices 0 (coil 0001 per axis), timers and counts 0.
REQ-041 Reset mid-RUN aborts with no done pulse.
REQ-042 Reset takes priority over cmd_valid and abort in the same cycle.

Structure
REQ-043 Package motion_pkg holds the FSM state enum, the mode enum, status code constants and the 4-entry phase table.
REQ-044 Sub-module stepper_axis, instantiated NAXES times, contains the period timer, remaining counter, phase index, limit check and active/limit/timeout flags.
REQ-045 The top level contains the FSM, command latch, flag reduction and status encoding.

Verification
REQ-046 NAXES=2, step_period=4, MOVE dir=10, steps={3,5}, no limits -> axis1 coil 0001->0010->0100->1000; axis0 five steps downward (1000,0100,0010,0001,1000); done at cycle 22 after accept; status 00.
REQ-047 MOVE axis0 dir=1, steps=100, step_period=2, limit_hi[0] asserted after 10 steps -> exactly 10 coil changes, axis_active[0] falls, done pulse, status 01.
REQ-048 HOME with limit_lo asserted after 7 steps on axis0 and after 12 on axis1 -> each axis stops at its limit, status 00; repeat with STEPW=4 and no limits -> 15 steps each, status 11.
REQ-049 abort 3 cycles into a 50-step move -> no coil change after the next edge, done within 2 cycles, status 10; a cmd_valid pulse during RUN is not accepted.
REQ-050 Zero-step MOVE -> done 2 cycles after accept, coil unchanged; a back-to-back command on the cycle after done is accepted; reset mid-RUN -> coil 0001 on every axis, busy 0, no done pulse.
